// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues sequential word fetches, buffers in-order
// responses in a small FIFO for the decoder, and discards stale responses after a redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_next
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t          buf_q [DEPTH];
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW:0]   occ;
  logic          pop, req_fire, resp_acc, push;
  ent_t          head;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_acc = imem_resp_valid & (inflight_q != '0);
  assign push     = resp_acc & (drop_q == '0) & !redirect_valid;
  assign pop      = instr_valid & instr_ready;
  assign req_fire = imem_req_valid & imem_req_ready;

  // Outstanding requests plus buffered entries never exceed DEPTH, so pushes always fit.
  assign occ            = {1'b0, inflight_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
  assign imem_req_valid = rst_n & !redirect_valid & (occ < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign head          = buf_q[rd_q];
  assign instr_valid   = rst_n & (count_q != '0) & !redirect_valid;
  assign instr         = rst_n ? head.instr : 32'h0;
  assign instr_pc      = rst_n ? head.pc : 32'h0;
  assign instr_pc_next = rst_n ? head.pc + 32'd4 : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      resp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      inflight_d = inflight_q - CW'(resp_acc);
      drop_d     = inflight_q - CW'(resp_acc);
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_acc);
      if (resp_acc && drop_q != '0) drop_d = drop_q - 1'b1;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_d      = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_q] <= '{instr: imem_resp_data, pc: resp_pc_q};
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == CW'(DEPTH)));
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: an in-order memory with random latency feeds the
// DUT, and a program-order PC model checks every request address and delivered instruction.
module tb_instr_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_next;

  instr_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_next(instr_pc_next)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc, last_due, lat_min, lat_max;
  int          total, bad;
  logic [31:0] exp_pc, exp_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    return h;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check settled outputs, update model.
  task automatic tick(input bit ir, input bit rv, input logic [31:0] rpc, input bit mr,
                      output bit iv, output bit qv);
    int lat, due;
    @(negedge clk);
    instr_ready    = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = mr;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    iv = instr_valid;
    qv = imem_req_valid;
    if (rv) begin
      chk("redir_no_pop", {31'b0, instr_valid}, 32'd0);
      chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    if (instr_valid && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, memf(exp_pc));
      chk("instr_pc_next", instr_pc_next, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due < last_due) due = last_due;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, due: due});
      exp_req = exp_req + 32'd4;
    end
    if (imem_resp_valid) void'(mq.pop_front());
    if (rv) begin
      exp_pc  = rpc & 32'hFFFF_FFFC;
      exp_req = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    bit iv, qv;
    total = 0; bad = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ivld", {31'b0, instr_valid}, 32'd0);
    chk("rst_rvld", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_pc_next", instr_pc_next, 32'd0);
    #1 rst_n = 1'b1;
    exp_pc = 32'h0; exp_req = 32'h0;

    // Back-to-back streaming with 1-cycle memory
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);
      chk("bb_req_vld", {31'b0, qv}, 32'd1);
      chk("bb_ivld", {31'b0, iv}, (k >= 2) ? 32'd1 : 32'd0);
    end

    // Decoder stall fills the buffer and throttles requests
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 32'h0, 1'b1, iv, qv);
    chk("stall_req_vld", {31'b0, qv}, 32'd0);
    chk("stall_ivld", {31'b0, iv}, 32'd1);
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);

    // Two outstanding with slow memory, then redirect to a misaligned target
    lat_min = 3; lat_max = 3;
    tick(1'b1, 1'b1, 32'h10, 1'b1, iv, qv);
    tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);
    tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);
    tick(1'b1, 1'b1, 32'h103, 1'b1, iv, qv);
    chk("redir_target", exp_req, 32'h100);
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);

    // Address wrap at the top of the space
    lat_min = 1; lat_max = 1;
    tick(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, iv, qv);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);

    // Redirect while a response arrives and the decoder would pop
    tick(1'b1, 1'b1, 32'h200, 1'b1, iv, qv);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);

    // Random traffic
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 800; k++)
      tick(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom, ($urandom % 4) != 0, iv, qv);
    for (int k = 0; k < 12; k++) tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);

    // Asynchronous reset with the buffer full
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 32'h0, 1'b1, iv, qv);
    chk("full_ivld", {31'b0, iv}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ivld", {31'b0, instr_valid}, 32'd0);
    chk("arst_rvld", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    mq.delete();
    last_due = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    exp_pc = 32'h0; exp_req = 32'h0;
    tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);
    chk("post_rst_req", {31'b0, qv}, 32'd1);
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 32'h0, 1'b1, iv, qv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
